// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: fetch-to-decode handshake bundle.
//   out_valid  queue head holds a valid instruction (fetch -> decode)
//   out_ready  decode accepts the head this cycle    (decode -> fetch)
//   out_instr  instruction at the queue head         (fetch -> decode)
//   out_pc     byte address of out_instr             (fetch -> decode)
// master = fetch side, slave = decode side.
interface ifetch_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer. Owns the fetch PC, drives the
// async-read instruction ROM address, and buffers {pc, instr} pairs in a
// small prefetch queue that decode drains over valid/ready. Handles
// branch/jump redirect (queue flush) and halt (stop fetching, keep draining).
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   rom_addr        ROM word address = pc[ADDR_W+1:2]
//   rom_data_in     ROM data, combinational from rom_addr
//   halt            stop issuing new fetches; queue still drains
//   redirect_valid  branch/jump taken this cycle
//   redirect_pc     target byte address, low 2 bits ignored
//   out_if          decode handshake (out_valid/out_ready/out_instr/out_pc)
//   fetch_count     instructions pushed since reset (wraps at 2^32)
module ifetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data_in,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  ifetch_ctrl_if.master     out_if,
  output logic [31:0]       fetch_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             head_valid;
  logic             pop;
  logic             push;

  assign rom_addr   = pc[ADDR_W+1:2];
  assign head_valid = (count != '0);

  // Push while full is legal only alongside a pop, which makes
  // out_ready feed push combinationally.
  assign pop  = head_valid & out_if.out_ready & ~redirect_valid;
  assign push = ~halt & ~redirect_valid & ((count < CNT_W'(DEPTH)) | pop);

  assign out_if.out_valid = head_valid;
  assign out_if.out_instr = head_valid ? instr_mem[rd_ptr] : '0;
  assign out_if.out_pc    = head_valid ? pc_mem[rd_ptr]    : '0;

  // Storage carries no reset; stale entries are masked by head_valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= rom_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + PTR_W'(1);
        pc          <= pc + 32'd4;
        fetch_count <= fetch_count + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data_in;
  logic          halt;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   fetch_count;

  // Second instance exercises the PC/ROM wrap with RESET_PC near the top.
  logic [AW-1:0] rom_addr2;
  logic [31:0]   rom_data_in2;
  logic [31:0]   fetch_count2;

  int checks   = 0;
  int failures = 0;

  ifetch_ctrl_if dec_if ();
  ifetch_ctrl_if dec_if2 ();

  // ROM[i] = i
  assign rom_data_in  = {{(32-AW){1'b0}}, rom_addr};
  assign rom_data_in2 = {{(32-AW){1'b0}}, rom_addr2};
  assign dec_if2.out_ready = 1'b1;

  ifetch_ctrl #(.DEPTH(4), .ADDR_W(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data_in    (rom_data_in),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_if         (dec_if.master),
    .fetch_count    (fetch_count)
  );

  ifetch_ctrl #(.DEPTH(4), .ADDR_W(AW), .RESET_PC(32'h0000_0FFC)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr2),
    .rom_data_in    (rom_data_in2),
    .halt           (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .out_if         (dec_if2.master),
    .fetch_count    (fetch_count2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    check_eq({tag, "_valid"}, {31'b0, dec_if.out_valid}, {31'b0, v});
    check_eq({tag, "_pc"}, dec_if.out_pc, pc);
    check_eq({tag, "_instr"}, dec_if.out_instr, ins);
  endtask

  initial begin
    rst            = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_if.out_ready = 1'b0;

    // 1: reset state, then streaming with out_ready=1; wrap instance alongside
    do_reset();
    check_head("rst", 1'b0, 32'h0, 32'h0);
    check_eq("rst_rom_addr", {22'b0, rom_addr}, 32'd0);
    check_eq("rst_fetch_count", fetch_count, 32'd0);
    check_eq("wrap_rst_rom_addr", {22'b0, rom_addr2}, 32'd1023);
    dec_if.out_ready = 1'b1;
    tick();
    check_head("t1_c1", 1'b1, 32'd0, 32'd0);
    check_eq("t1_fc1", fetch_count, 32'd1);
    check_eq("wrap_pc0", dec_if2.out_pc, 32'h0000_0FFC);
    check_eq("wrap_instr0", dec_if2.out_instr, 32'd1023);
    check_eq("wrap_rom_addr1", {22'b0, rom_addr2}, 32'd0);
    tick();
    check_head("t1_c2", 1'b1, 32'd4, 32'd1);
    check_eq("wrap_pc1", dec_if2.out_pc, 32'h0000_1000);
    check_eq("wrap_instr1", dec_if2.out_instr, 32'd0);
    tick();
    check_head("t1_c3", 1'b1, 32'd8, 32'd2);
    tick();
    check_head("t1_c4", 1'b1, 32'd12, 32'd3);
    check_eq("t1_fc4", fetch_count, 32'd4);

    // 2: backpressure fills the queue, then drains back-to-back
    dec_if.out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    check_eq("t2_rom_addr_full", {22'b0, rom_addr}, 32'd4);
    check_eq("t2_fc_full", fetch_count, 32'd4);
    check_head("t2_head_full", 1'b1, 32'd0, 32'd0);
    dec_if.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_head($sformatf("t2_drain%0d", i), 1'b1, 32'(4 * i), 32'(i));
    end

    // 3: misaligned redirect with 3 entries queued flushes the queue
    dec_if.out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    check_eq("t3_fc_pre", fetch_count, 32'd3);
    dec_if.out_ready = 1'b1;
    redirect_valid   = 1'b1;
    redirect_pc      = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check_head("t3_flush", 1'b0, 32'h0, 32'h0);
    check_eq("t3_rom_addr", {22'b0, rom_addr}, 32'h40);
    check_eq("t3_fc_flush", fetch_count, 32'd3);
    tick();
    check_head("t3_target", 1'b1, 32'h100, 32'h40);
    check_eq("t3_fc_target", fetch_count, 32'd4);

    // 4: halt drains 2 entries, freezes pc, resumes on release
    dec_if.out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    halt = 1'b1;
    dec_if.out_ready = 1'b1;
    check_head("t4_h0", 1'b1, 32'd0, 32'd0);
    tick();
    check_head("t4_h1", 1'b1, 32'd4, 32'd1);
    tick();
    check_head("t4_empty", 1'b0, 32'h0, 32'h0);
    tick();
    check_head("t4_still_empty", 1'b0, 32'h0, 32'h0);
    check_eq("t4_rom_addr_frozen", {22'b0, rom_addr}, 32'd2);
    check_eq("t4_fc_frozen", fetch_count, 32'd2);
    halt = 1'b0;
    tick();
    check_head("t4_resume", 1'b1, 32'd8, 32'd2);
    check_eq("t4_fc_resume", fetch_count, 32'd3);

    // 6: reset wins over simultaneous redirect and handshake
    for (int i = 0; i < 3; i++) tick();
    rst              = 1'b1;
    redirect_valid   = 1'b1;
    redirect_pc      = 32'h0000_0200;
    dec_if.out_ready = 1'b1;
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    check_head("t6_rst", 1'b0, 32'h0, 32'h0);
    check_eq("t6_rom_addr", {22'b0, rom_addr}, 32'd0);
    check_eq("t6_fc", fetch_count, 32'd0);
    tick();
    check_head("t6_first", 1'b1, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
